// File: rtl/pulse_hs_sync_multi.sv
// pulse_hs_sync_multi
//   Multi-channel pulse synchronizer from i_clk_1 to i_clk_2.
//   Each channel queues source pulses in a saturating pending counter and
//   delivers them one at a time over a toggle req/ack handshake. Every
//   queued pulse becomes exactly one single-cycle pulse in i_clk_2.
//   Optional feature: define PULSE_SYNC_DROP_CNT_EN to add per-channel
//   saturating drop counters on o_drop_cnt.
module pulse_hs_sync_multi #(
  parameter int CHANNELS    = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_CNT_W  = 8
) (
  input  logic                           i_clk_1,
  input  logic                           i_rst_n,
  input  logic                           i_clk_2,
  input  logic [CHANNELS-1:0]            i_pulse,
  output logic [CHANNELS-1:0]            o_busy,
  output logic [CHANNELS-1:0]            o_overflow,
  output logic [CHANNELS-1:0]            o_pulse
`ifdef PULSE_SYNC_DROP_CNT_EN
  ,
  output logic [CHANNELS*DROP_CNT_W-1:0] o_drop_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  // Elaboration-time guard on parameter ranges.
  if (CHANNELS < 1 || DEPTH < 1 || SYNC_STAGES < 2 || DROP_CNT_W < 1) begin : g_param_chk
    $error("pulse_hs_sync_multi: illegal parameter value");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          room;
    logic                   req;
    logic                   launch;
    logic                   accept;
    logic                   ack_done;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   edge_q;

    // A launch only happens from IDLE, so a pulse arriving with an empty
    // queue is counted first and launched one cycle later.
    assign launch   = (state == IDLE) && (cnt != '0);
    assign ack_done = (state == WAIT_ACK) && (ack_sync[SYNC_STAGES-1] == req);

    // Occupancy after this cycle's launch decides whether a new pulse fits.
    assign room     = cnt - CW'(launch);
    assign accept   = i_pulse[c] && (room < DEPTH_C);

    // Drop strobe is asserted in the same cycle as the rejected input.
    assign o_overflow[c] = i_pulse[c] & ~accept;
    assign o_busy[c]     = (state == WAIT_ACK) | (cnt != '0);

    // Source side: pending counter and request/acknowledge FSM.
    always_ff @(posedge i_clk_1 or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state <= IDLE;
        cnt   <= '0;
        req   <= 1'b0;
      end else begin
        cnt <= cnt + CW'(accept) - CW'(launch);
        case (state)
          IDLE: begin
            if (launch) begin
              req   <= ~req;
              state <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            if (ack_done) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end

    // Source side: bring the acknowledge toggle back into i_clk_1.
    always_ff @(posedge i_clk_1 or negedge i_rst_n) begin
      if (!i_rst_n) ack_sync <= '0;
      else          ack_sync <= {ack_sync[SYNC_STAGES-2:0], edge_q};
    end

    // Destination side: synchronize the request toggle and keep its last
    // value; the edge flop doubles as the acknowledge toggle.
    always_ff @(posedge i_clk_2 or negedge i_rst_n) begin
      if (!i_rst_n) begin
        req_sync <= '0;
        edge_q   <= 1'b0;
      end else begin
        req_sync <= {req_sync[SYNC_STAGES-2:0], req};
        edge_q   <= req_sync[SYNC_STAGES-1];
      end
    end

    assign o_pulse[c] = req_sync[SYNC_STAGES-1] ^ edge_q;

`ifdef PULSE_SYNC_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt;

    // Count dropped pulses, holding at the maximum value.
    always_ff @(posedge i_clk_1 or negedge i_rst_n) begin
      if (!i_rst_n)                             drop_cnt <= '0;
      else if (o_overflow[c] && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end

    assign o_drop_cnt[c*DROP_CNT_W +: DROP_CNT_W] = drop_cnt;
`endif
  end

endmodule

// File: tb/tb_pulse_hs_sync_multi.sv
// Directed testbench for pulse_hs_sync_multi (CHANNELS=2, DEPTH=4,
// SYNC_STAGES=2, i_clk_1 = 100 MHz, i_clk_2 = 25 MHz). With
// PULSE_SYNC_DROP_CNT_EN defined the drop counter scenario is added.
module tb_pulse_hs_sync_multi;

  localparam int CH = 2;
  localparam int DW = 2;

  logic          clk1 = 1'b0;
  logic          clk2 = 1'b0;
  logic          rst_n;
  logic [CH-1:0] pulse;
  logic [CH-1:0] busy;
  logic [CH-1:0] overflow;
  logic [CH-1:0] opulse;
`ifdef PULSE_SYNC_DROP_CNT_EN
  logic [CH*DW-1:0] drop;
`endif

  pulse_hs_sync_multi #(
    .CHANNELS   (CH),
    .DEPTH      (4),
    .SYNC_STAGES(2),
    .DROP_CNT_W (DW)
  ) dut (
    .i_clk_1   (clk1),
    .i_rst_n   (rst_n),
    .i_clk_2   (clk2),
    .i_pulse   (pulse),
    .o_busy    (busy),
    .o_overflow(overflow),
    .o_pulse   (opulse)
`ifdef PULSE_SYNC_DROP_CNT_EN
    ,
    .o_drop_cnt(drop)
`endif
  );

  initial forever #5 clk1 = ~clk1;
  initial forever #20 clk2 = ~clk2;

  int n_chk  = 0;
  int n_pass = 0;
  int pcnt [CH];
  int ovcnt[CH];
  int seperr = 0;
  int e2cnt  = 0;
  logic [CH-1:0] prev = '0;

  initial begin
    for (int c = 0; c < CH; c++) begin
      pcnt[c]  = 0;
      ovcnt[c] = 0;
    end
  end

  always @(posedge clk2) e2cnt++;

  // Count delivered pulses and flag any that last more than one cycle.
  always @(negedge clk2) begin
    for (int c = 0; c < CH; c++) begin
      if (opulse[c]) begin
        pcnt[c]++;
        if (prev[c]) seperr++;
      end
    end
    prev = opulse;
  end

  always @(negedge clk1) begin
    for (int c = 0; c < CH; c++)
      if (overflow[c]) ovcnt[c]++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive(input logic [CH-1:0] v);
    @(posedge clk1);
    #1 pulse = v;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000 && busy != '0; i++) @(negedge clk1);
    check_eq(tag, int'(busy), 0);
    repeat (3) @(negedge clk2);
  endtask

  int b0, b1, ob0, ob1, lat, e2start, nov;
  logic [5:0] mask;
  logic       mid_done;

  initial begin
    rst_n = 1'b0;
    pulse = '0;
    repeat (3) @(negedge clk2);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_ovf", int'(overflow), 0);
    check_eq("rst_pulse", int'(opulse), 0);
    #3 rst_n = 1'b1;
    repeat (4) @(negedge clk2);

    // 1: single pulse on ch0
    b0 = pcnt[0]; b1 = pcnt[1]; ob0 = ovcnt[0]; ob1 = ovcnt[1];
    drive(2'b01);
    drive(2'b00);
    @(posedge clk1);
    #1 e2start = e2cnt;
    check_eq("t1_busy", int'(busy[0]), 1);
    for (int i = 0; i < 40 && !opulse[0]; i++) @(negedge clk2);
    lat = e2cnt - e2start;
    check_eq("t1_rise", int'(opulse[0]), 1);
    check_eq("t1_latency_2to3", (lat >= 2 && lat <= 3) ? 1 : 0, 1);
    wait_idle("t1_idle");
    check_eq("t1_ch0_cnt", pcnt[0] - b0, 1);
    check_eq("t1_ch1_cnt", pcnt[1] - b1, 0);
    check_eq("t1_ovf", (ovcnt[0] - ob0) + (ovcnt[1] - ob1), 0);

    // 2: four ch1 pulses spaced two cycles apart
    b0 = pcnt[0]; b1 = pcnt[1]; ob0 = ovcnt[0]; ob1 = ovcnt[1];
    for (int i = 0; i < 4; i++) begin
      drive(2'b10);
      drive(2'b00);
    end
    wait_idle("t2_idle");
    check_eq("t2_ch1_cnt", pcnt[1] - b1, 4);
    check_eq("t2_ch0_cnt", pcnt[0] - b0, 0);
    check_eq("t2_ovf", (ovcnt[0] - ob0) + (ovcnt[1] - ob1), 0);

    // 3: six back-to-back ch0 pulses, sixth dropped
    b0 = pcnt[0]; ob0 = ovcnt[0];
    for (int i = 0; i < 6; i++) begin
      drive(2'b01);
      @(negedge clk1);
      mask[i] = overflow[0];
    end
    drive(2'b00);
    check_eq("t3_ovf_mask", int'(mask), 32);
    wait_idle("t3_idle");
    check_eq("t3_ch0_cnt", pcnt[0] - b0, 5);
    check_eq("t3_ovf_cnt", ovcnt[0] - ob0, 1);

    // 4: simultaneous bursts on both channels
    b0 = pcnt[0]; b1 = pcnt[1]; ob0 = ovcnt[0]; ob1 = ovcnt[1];
    drive(2'b11);
    drive(2'b11);
    drive(2'b01);
    drive(2'b00);
    wait_idle("t4_idle");
    check_eq("t4_ch0_cnt", pcnt[0] - b0, 3);
    check_eq("t4_ch1_cnt", pcnt[1] - b1, 2);
    check_eq("t4_ovf", (ovcnt[0] - ob0) + (ovcnt[1] - ob1), 0);

    // 5: reset with ch0 waiting for ack and three pulses pending
    b0 = pcnt[0];
    for (int i = 0; i < 4; i++) drive(2'b01);
    drive(2'b00);
    check_eq("t5_busy_pre", int'(busy[0]), 1);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk2);
    check_eq("t5_busy_rst", int'(busy), 0);
    #3 rst_n = 1'b1;
    repeat (20) @(negedge clk2);
    check_eq("t5_no_pulse", pcnt[0] - b0, 0);
    check_eq("t5_busy_post", int'(busy), 0);
    b0 = pcnt[0];
    drive(2'b01);
    drive(2'b00);
    wait_idle("t5_idle");
    check_eq("t5_fresh_cnt", pcnt[0] - b0, 1);

`ifdef PULSE_SYNC_DROP_CNT_EN
    // 6: ten overflow events on ch1 saturate its 2-bit drop counter
    nov = 0;
    mid_done = 1'b0;
    for (int i = 0; i < 100 && nov < 10; i++) begin
      drive(2'b10);
      @(negedge clk1);
      if (overflow[1]) begin
        nov++;
        if (nov == 3 && !mid_done) begin
          mid_done = 1'b1;
          check_eq("t6_drop_mid", int'(drop[DW +: DW]), 2);
        end
      end
    end
    drive(2'b00);
    check_eq("t6_ovf_events", nov, 10);
    @(negedge clk1);
    check_eq("t6_drop_ch1", int'(drop[DW +: DW]), 3);
    check_eq("t6_drop_ch0", int'(drop[0 +: DW]), 0);
    wait_idle("t6_idle");
`endif

    check_eq("pulse_separation", seperr, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
